// File: rtl/tdc_spi_master_n.sv
// SPI master for TDC register/result access: parametrised word width, SCK divider,
// SPI mode and CS timing, with multi-word frames kept under one chip-select.
module tdc_spi_master_n #(
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 2,
    parameter bit CPOL     = 1'b0,
    parameter bit CPHA     = 1'b0,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              cs_end,
    input  logic              miso,
    output logic              mosi,
    output logic              sck,
    output logic              cs_n,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              new_data
);

    localparam int EDGES  = 2 * DATA_W;
    localparam int EDGE_W = $clog2(EDGES);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MAX_SH = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int MAX_PH = (MAX_SH > CS_GAP) ? MAX_SH : CS_GAP;
    localparam int PH_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t              state, state_next;
    logic [DATA_W-1:0]   tx, rx, rx_next;
    logic [EDGE_W-1:0]   edge_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic [PH_W-1:0]     ph_cnt;
    logic                cs_end_q;
    logic                accept, sck_edge, last_edge, sample, drive;

    assign busy = (state != IDLE);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        sck_edge   = 1'b0;
        last_edge  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = cs_n ? SETUP : XFER;
                end
            end
            SETUP: if (ph_cnt == PH_W'(CS_SETUP - 1)) state_next = XFER;
            XFER: begin
                sck_edge  = (div_cnt == DIV_W'(CLK_DIV - 1));
                last_edge = sck_edge && (edge_cnt == EDGE_W'(EDGES - 1));
                if (last_edge) state_next = HOLD;
            end
            HOLD: if (ph_cnt == PH_W'(CS_HOLD - 1)) state_next = cs_end_q ? GAP : IDLE;
            GAP:  if (ph_cnt == PH_W'(CS_GAP - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // even edge index = leading edge; CPHA selects which edge kind samples
        sample  = sck_edge && (edge_cnt[0] == CPHA);
        drive   = sck_edge && (edge_cnt[0] != CPHA) && !last_edge;
        rx_next = sample ? {rx[DATA_W-2:0], miso} : rx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cs_n     <= 1'b1;
            sck      <= CPOL;
            mosi     <= 1'b0;
            data_out <= '0;
            new_data <= 1'b0;
            tx       <= '0;
            rx       <= '0;
            cs_end_q <= 1'b0;
            edge_cnt <= '0;
            div_cnt  <= '0;
            ph_cnt   <= '0;
        end else begin
            state    <= state_next;
            new_data <= 1'b0;
            rx       <= rx_next;

            if (state_next != state)
                ph_cnt <= '0;
            else if (state == SETUP || state == HOLD || state == GAP)
                ph_cnt <= ph_cnt + 1'b1;

            if (accept) begin
                cs_end_q <= cs_end;
                if (cs_n) begin
                    cs_n <= 1'b0;
                    tx   <= data_in;
                end else if (!CPHA) begin
                    // continuation word enters XFER directly, so its MSB goes out now
                    mosi <= data_in[DATA_W-1];
                    tx   <= {data_in[DATA_W-2:0], 1'b0};
                end else begin
                    tx <= data_in;
                end
            end

            if (state == SETUP && state_next == XFER && !CPHA) begin
                mosi <= tx[DATA_W-1];
                tx   <= {tx[DATA_W-2:0], 1'b0};
            end

            if (state == XFER) begin
                if (sck_edge) begin
                    div_cnt  <= '0;
                    sck      <= ~sck;
                    edge_cnt <= last_edge ? '0 : edge_cnt + 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
                if (drive) begin
                    mosi <= tx[DATA_W-1];
                    tx   <= {tx[DATA_W-2:0], 1'b0};
                end
                if (last_edge) begin
                    data_out <= rx_next;
                    new_data <= 1'b1;
                end
            end

            if (state == HOLD && state_next == GAP)
                cs_n <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tdc_spi_master_n.sv
// Bench for tdc_spi_master_n: four parameter sets, loopback and slave-model traffic,
// timing measured per word against values computed from the transfer rules.
module tb_tdc_spi_master_n;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  start_v = '0;
    logic [3:0]  ce_v = '0;
    logic [31:0] din_v [4];
    logic [3:0]  mosi_v, sck_v, csn_v, busy_v, nd_v;
    logic [7:0]  dout_a, dout_b, dout_d;
    logic [15:0] dout_c;
    logic        sl_miso = 1'b0;
    logic [7:0]  sl_word = '0;
    logic [7:0]  sl_rx = '0;
    int          sl_idx = 7;
    logic [3:0]  frame_open = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    // a: mode 0, 8 bit, div 2, loopback
    tdc_spi_master_n #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .data_in(din_v[0][7:0]), .cs_end(ce_v[0]),
        .miso(mosi_v[0]), .mosi(mosi_v[0]), .sck(sck_v[0]), .cs_n(csn_v[0]),
        .busy(busy_v[0]), .data_out(dout_a), .new_data(nd_v[0]));

    // b: mode 3, 8 bit, div 2, slave model
    tdc_spi_master_n #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .data_in(din_v[1][7:0]), .cs_end(ce_v[1]),
        .miso(sl_miso), .mosi(mosi_v[1]), .sck(sck_v[1]), .cs_n(csn_v[1]),
        .busy(busy_v[1]), .data_out(dout_b), .new_data(nd_v[1]));

    // c: mode 0, 16 bit, div 2, loopback
    tdc_spi_master_n #(.DATA_W(16), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .data_in(din_v[2][15:0]), .cs_end(ce_v[2]),
        .miso(mosi_v[2]), .mosi(mosi_v[2]), .sck(sck_v[2]), .cs_n(csn_v[2]),
        .busy(busy_v[2]), .data_out(dout_c), .new_data(nd_v[2]));

    // d: mode 0, 8 bit, div 5, loopback
    tdc_spi_master_n #(.DATA_W(8), .CLK_DIV(5), .CPOL(1'b0), .CPHA(1'b0)) u_d (
        .clk(clk), .rst(rst), .start(start_v[3]), .data_in(din_v[3][7:0]), .cs_end(ce_v[3]),
        .miso(mosi_v[3]), .mosi(mosi_v[3]), .sck(sck_v[3]), .cs_n(csn_v[3]),
        .busy(busy_v[3]), .data_out(dout_d), .new_data(nd_v[3]));

    // mode-3 slave: drive on falling (leading) edges, capture on rising (trailing) edges
    always @(negedge sck_v[1] or posedge csn_v[1]) begin
        if (csn_v[1]) begin
            sl_idx = 7;
        end else begin
            sl_miso = sl_word[sl_idx];
            sl_idx  = sl_idx - 1;
        end
    end

    always @(posedge sck_v[1])
        if (csn_v[1] == 1'b0) sl_rx = {sl_rx[6:0], mosi_v[1]};

    function automatic int w_of(input int k);
        return (k == 2) ? 16 : 8;
    endfunction

    function automatic int d_of(input int k);
        return (k == 3) ? 5 : 2;
    endfunction

    function automatic logic cpol_of(input int k);
        return (k == 1);
    endfunction

    function automatic logic [31:0] dout_of(input int k);
        case (k)
            0:       return 32'(dout_a);
            1:       return 32'(dout_b);
            2:       return 32'(dout_c);
            default: return 32'(dout_d);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One word on instance k; called and returns on a falling clock edge.
    task automatic run_word(input int k, input logic [31:0] data, input logic ce,
                            input logic [31:0] exp_dout, input logic hammer);
        int w, d, setup, xfer, edges, first_edge, last_edge, bad_gap;
        int nd_cyc, nd_cnt, low_busy, high_busy, bad_mosi;
        logic prev_sck, prev_mosi;
        w = w_of(k);
        d = d_of(k);
        setup = frame_open[k] ? 0 : 2;
        xfer = 2 * w * d;
        edges = 0; first_edge = -1; last_edge = 0; bad_gap = 0;
        nd_cyc = -1; nd_cnt = 0; low_busy = 0; high_busy = 0; bad_mosi = 0;
        din_v[k] = data;
        ce_v[k] = ce;
        start_v[k] = 1'b1;
        prev_sck = sck_v[k];
        prev_mosi = mosi_v[k];
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (hammer) begin
                din_v[k] = $urandom;
                ce_v[k] = 1'($urandom_range(0, 1));
            end else begin
                start_v[k] = 1'b0;
            end
            if (sck_v[k] != prev_sck) begin
                edges++;
                if (first_edge < 0) first_edge = cyc;
                else if (cyc - last_edge != d) bad_gap++;
                last_edge = cyc;
            end
            if (k == 1 && mosi_v[k] != prev_mosi && !(prev_sck && !sck_v[k])) bad_mosi++;
            prev_sck = sck_v[k];
            prev_mosi = mosi_v[k];
            if (nd_v[k]) begin
                nd_cnt++;
                if (nd_cyc < 0) nd_cyc = cyc;
            end
            if (!busy_v[k]) break;
            if (!csn_v[k]) low_busy++;
            else high_busy++;
        end
        start_v[k] = 1'b0;
        check($sformatf("k%0d latency", k), nd_cyc, 1 + setup + xfer);
        check($sformatf("k%0d new_data_pulses", k), nd_cnt, 1);
        check($sformatf("k%0d sck_edges", k), edges, 2 * w);
        check($sformatf("k%0d sck_spacing_errs", k), bad_gap, 0);
        check($sformatf("k%0d first_edge", k), first_edge, 1 + setup + d);
        check($sformatf("k%0d data_out", k), dout_of(k), exp_dout);
        check($sformatf("k%0d cs_low_cycles", k), low_busy, setup + xfer + 2);
        check($sformatf("k%0d gap_cycles", k), high_busy, ce ? 2 : 0);
        check($sformatf("k%0d cs_n_after", k), csn_v[k], ce);
        check($sformatf("k%0d sck_idle", k), sck_v[k], cpol_of(k));
        if (k == 1) check("k1 mosi_change_not_on_fall", bad_mosi, 0);
        frame_open[k] = !ce;
    endtask

    initial begin : main
        int edges_seen, nd_seen, k;
        logic prev;
        logic [31:0] data, exp;
        logic ce;
        foreach (din_v[i]) din_v[i] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("k%0d rst cs_n", i), csn_v[i], 1'b1);
            check($sformatf("k%0d rst sck", i), sck_v[i], cpol_of(i));
            check($sformatf("k%0d rst mosi", i), mosi_v[i], 1'b0);
            check($sformatf("k%0d rst busy", i), busy_v[i], 1'b0);
            check($sformatf("k%0d rst data_out", i), dout_of(i), 0);
            check($sformatf("k%0d rst new_data", i), nd_v[i], 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);

        run_word(0, 32'hA5, 1'b1, 32'hA5, 1'b0);

        sl_word = 8'h3C;
        run_word(1, 32'hC3, 1'b1, 32'h3C, 1'b0);
        check("k1 slave_rx", 32'(sl_rx), 32'hC3);

        run_word(2, 32'h1234, 1'b0, 32'h1234, 1'b0);
        run_word(2, 32'hBEEF, 1'b1, 32'hBEEF, 1'b0);

        data = $urandom_range(1, 255);
        run_word(3, data, 1'b1, data, 1'b0);

        run_word(0, 32'h96, 1'b1, 32'h96, 1'b1);

        // reset right after the 7th sck edge of a mode-0 word
        din_v[0] = 32'h5A;
        ce_v[0] = 1'b1;
        start_v[0] = 1'b1;
        edges_seen = 0;
        nd_seen = 0;
        prev = sck_v[0];
        for (int c = 0; c < 200 && edges_seen < 7; c++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            if (sck_v[0] != prev) edges_seen++;
            prev = sck_v[0];
            if (nd_v[0]) nd_seen++;
        end
        check("rst_mid edges_reached", edges_seen, 7);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst_mid cs_n", csn_v[0], 1'b1);
        check("rst_mid sck", sck_v[0], 1'b0);
        check("rst_mid busy", busy_v[0], 1'b0);
        check("rst_mid data_out", dout_of(0), 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (nd_v[0]) nd_seen++;
        end
        check("rst_mid new_data", nd_seen, 0);
        frame_open = '0;
        run_word(0, 32'h69, 1'b1, 32'h69, 1'b0);

        for (int i = 0; i < 14; i++) begin
            k = $urandom_range(0, 1);
            data = $urandom & 32'hFF;
            if (k == 1) begin
                sl_word = 8'($urandom);
                exp = 32'(sl_word);
                ce = 1'b1;
            end else begin
                exp = data;
                ce = 1'($urandom_range(0, 1));
            end
            run_word(k, data, ce, exp, 1'($urandom_range(0, 1)));
            if (k == 1) check("k1 rand slave_rx", 32'(sl_rx), data);
        end
        if (frame_open[0]) run_word(0, 32'h0F, 1'b1, 32'h0F, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
